// File: rtl/ex_operand_stage.sv
// Execute stage: ID/EX and EX/MEM pipeline registers, forwarding operand
// muxes, a small ALU and the load-use interlock.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dest,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [2:0]        id_aluop,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [REG_W-1:0]  memwb_dest,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [REG_W-1:0]  idex_rs,
  output logic [REG_W-1:0]  idex_rt,
  output logic [REG_W-1:0]  exmem_dest_fwd,
  output logic [REG_W-1:0]  memwb_dest_fwd,
  output logic              stall,
  output logic              exmem_valid,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic [DATA_W-1:0] exmem_store_data,
  output logic [REG_W-1:0]  exmem_dest,
  output logic              exmem_regwrite,
  output logic              exmem_memread,
  output logic              exmem_memwrite
);

  logic              idex_valid;
  logic [REG_W-1:0]  idex_dest;
  logic [DATA_W-1:0] idex_rs_data;
  logic [DATA_W-1:0] idex_rt_data;
  logic [DATA_W-1:0] idex_imm;
  logic              idex_alusrc;
  logic [2:0]        idex_aluop;
  logic              idex_regwrite;
  logic              idex_memread;
  logic              idex_memwrite;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_out;
  logic              slt_bit;
  logic              load_bubble;

  // Load-use interlock: the load in EX cannot supply its data in time for
  // the instruction in ID. Operand B only matters when it is not the immediate.
  always_comb begin
    stall = idex_valid && idex_memread && (idex_dest != '0) && id_valid &&
            ((idex_dest == id_rs) || ((idex_dest == id_rt) && !id_alusrc));
  end

  assign load_bubble    = flush || stall;
  assign memwb_dest_fwd = memwb_dest;
  assign exmem_dest_fwd = (exmem_valid && exmem_regwrite) ? exmem_dest : '0;

  // Operand selection; register $0 always reads as zero whatever forward code arrives.
  always_comb begin
    op_a = idex_rs_data;
    if (idex_rs == '0) begin
      op_a = '0;
    end else begin
      case (forward_a)
        2'b01:   op_a = exmem_alu_result;
        2'b10:   op_a = memwb_result;
        default: op_a = idex_rs_data;
      endcase
    end
    fwd_b = idex_rt_data;
    if (idex_rt == '0) begin
      fwd_b = '0;
    end else begin
      case (forward_b)
        2'b01:   fwd_b = exmem_alu_result;
        2'b10:   fwd_b = memwb_result;
        default: fwd_b = idex_rt_data;
      endcase
    end
    op_b = idex_alusrc ? idex_imm : fwd_b;
  end

  assign slt_bit = $signed(op_a) < $signed(op_b);

  // ALU; unused opcodes fall back to add.
  always_comb begin
    alu_out = op_a + op_b;
    case (idex_aluop)
      3'b001:  alu_out = op_a - op_b;
      3'b010:  alu_out = op_a & op_b;
      3'b011:  alu_out = op_a | op_b;
      3'b100:  alu_out = {{(DATA_W-1){1'b0}}, slt_bit};
      default: alu_out = op_a + op_b;
    endcase
  end

  // ID/EX register: a flush or interlock loads a full bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid    <= 1'b0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_dest     <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_alusrc   <= 1'b0;
      idex_aluop    <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
    end else if (load_bubble) begin
      idex_valid    <= 1'b0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_dest     <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_alusrc   <= 1'b0;
      idex_aluop    <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
    end else begin
      idex_valid    <= id_valid;
      idex_rs       <= id_rs;
      idex_rt       <= id_rt;
      idex_dest     <= id_dest;
      idex_rs_data  <= id_rs_data;
      idex_rt_data  <= id_rt_data;
      idex_imm      <= id_imm;
      idex_alusrc   <= id_alusrc;
      idex_aluop    <= id_aluop;
      idex_regwrite <= id_regwrite && id_valid;
      idex_memread  <= id_memread && id_valid;
      idex_memwrite <= id_memwrite && id_valid;
    end
  end

  // EX/MEM register: advances every cycle; store data is the forwarded B operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_valid      <= 1'b0;
      exmem_alu_result <= '0;
      exmem_store_data <= '0;
      exmem_dest       <= '0;
      exmem_regwrite   <= 1'b0;
      exmem_memread    <= 1'b0;
      exmem_memwrite   <= 1'b0;
    end else begin
      exmem_valid      <= idex_valid;
      exmem_alu_result <= alu_out;
      exmem_store_data <= fwd_b;
      exmem_dest       <= idex_dest;
      exmem_regwrite   <= idex_regwrite;
      exmem_memread    <= idex_memread;
      exmem_memwrite   <= idex_memwrite;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus pushes hand-computed results
// into a scoreboard, a monitor pops them as EX/MEM presents valid instructions.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc;
  logic [2:0]  id_aluop;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        flush;
  logic [1:0]  forward_a, forward_b;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_result;
  logic [4:0]  idex_rs, idex_rt, exmem_dest_fwd, memwb_dest_fwd;
  logic        stall, exmem_valid;
  logic [31:0] exmem_alu_result, exmem_store_data;
  logic [4:0]  exmem_dest;
  logic        exmem_regwrite, exmem_memread, exmem_memwrite;

  ex_operand_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .flush(flush), .forward_a(forward_a), .forward_b(forward_b),
    .memwb_dest(memwb_dest), .memwb_result(memwb_result),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .exmem_dest_fwd(exmem_dest_fwd),
    .memwb_dest_fwd(memwb_dest_fwd), .stall(stall), .exmem_valid(exmem_valid),
    .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data),
    .exmem_dest(exmem_dest), .exmem_regwrite(exmem_regwrite),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsd, rtd, imm;
    logic        alusrc;
    logic [2:0]  op;
    logic        rw, mr, mw;
    logic [1:0]  fa, fb;
    logic [31:0] mwb;
    logic        fl;
    logic        nopush;
    logic [31:0] exp_res, exp_store;
  } instr_t;

  typedef struct {
    logic [31:0] res, store;
    logic [4:0]  dest;
    logic [2:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  pfa = 2'b00, pfb = 2'b00;
  logic [31:0] pmwb = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                                input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                                input logic alusrc, input logic [2:0] op,
                                input logic rw, input logic mr, input logic mw,
                                input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] mwb,
                                input logic [31:0] exp_res, input logic [31:0] exp_store);
    instr_t t;
    t.v = 1'b1; t.rs = rs; t.rt = rt; t.dest = dest;
    t.rsd = rsd; t.rtd = rtd; t.imm = imm; t.alusrc = alusrc; t.op = op;
    t.rw = rw; t.mr = mr; t.mw = mw; t.fa = fa; t.fb = fb; t.mwb = mwb;
    t.fl = 1'b0; t.nopush = 1'b0; t.exp_res = exp_res; t.exp_store = exp_store;
    return t;
  endfunction

  task automatic zero_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_alusrc = 0; id_aluop = 0; id_regwrite = 0; id_memread = 0;
    id_memwrite = 0; flush = 0; forward_a = 0; forward_b = 0; memwb_dest = 0;
    memwb_result = 0;
  endtask

  // Present one instruction at ID; forward codes belong to the one now in EX.
  task automatic issue(input instr_t in, input logic exp_stall, input logic check_bubble);
    @(negedge clk);
    if (check_bubble) chk("bubble_valid", {31'b0, exmem_valid}, 32'd0);
    forward_a = pfa; forward_b = pfb; memwb_result = pmwb;
    memwb_dest = in.dest ^ 5'h15;
    id_valid = in.v; id_rs = in.rs; id_rt = in.rt; id_dest = in.dest;
    id_rs_data = in.rsd; id_rt_data = in.rtd; id_imm = in.imm;
    id_alusrc = in.alusrc; id_aluop = in.op; id_regwrite = in.rw;
    id_memread = in.mr; id_memwrite = in.mw; flush = in.fl;
    #1;
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    chk("memwb_dest_fwd", {27'b0, memwb_dest_fwd}, {27'b0, memwb_dest});
    if (stall && !in.fl) begin
      @(negedge clk);
      forward_a = 2'b00; forward_b = 2'b00;
      #1 chk("stall_one_cycle", {31'b0, stall}, 32'd0);
    end
    if (in.v && !in.fl && !in.nopush)
      sb.push_back('{res: in.exp_res, store: in.exp_store, dest: in.dest, ctl: {in.rw, in.mr, in.mw}});
    pfa  = in.fl ? 2'b00 : in.fa;
    pfb  = in.fl ? 2'b00 : in.fb;
    pmwb = in.mwb;
  endtask

  task automatic idle();
    @(negedge clk);
    zero_inputs();
    forward_a = pfa; forward_b = pfb; memwb_result = pmwb;
    pfa = 2'b00; pfb = 2'b00; pmwb = 32'h0;
  endtask

  // Monitor: every valid EX/MEM output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && exmem_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result %h with nothing expected", exmem_alu_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_result", exmem_alu_result, e.res);
        chk("store_data", exmem_store_data, e.store);
        chk("dest", {27'b0, exmem_dest}, {27'b0, e.dest});
        chk("ctl", {29'b0, exmem_regwrite, exmem_memread, exmem_memwrite}, {29'b0, e.ctl});
        chk("exmem_dest_fwd", {27'b0, exmem_dest_fwd}, {27'b0, (e.ctl[2] ? e.dest : 5'd0)});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t;
    logic [31:0] r;
    zero_inputs();
    rst_n = 0;
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r = $urandom; id_valid = r[0]; id_rs = r[5:1]; id_rt = r[10:6]; id_dest = r[15:11];
      id_alusrc = r[16]; id_aluop = r[19:17]; id_regwrite = r[20]; id_memread = r[21];
      id_memwrite = r[22]; flush = r[23]; forward_a = r[25:24]; forward_b = r[27:26];
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; memwb_result = $urandom;
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_exmem_valid", {31'b0, exmem_valid}, 32'd0);
    end
    chk("rst_alu_result", exmem_alu_result, 32'd0);
    chk("rst_store_data", exmem_store_data, 32'd0);
    chk("rst_dest", {27'b0, exmem_dest}, 32'd0);
    chk("rst_ctl", {29'b0, exmem_regwrite, exmem_memread, exmem_memwrite}, 32'd0);
    chk("rst_idex_rs", {27'b0, idex_rs}, 32'd0);
    chk("rst_idex_rt", {27'b0, idex_rt}, 32'd0);
    @(negedge clk);
    zero_inputs();
    rst_n = 1;

    // rs rt dest rsd rtd imm alusrc op rw mr mw fa fb mwb exp_res exp_store
    issue(mk(1, 2, 1, 5, 7, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 12, 7), 0, 0);
    issue(mk(2, 4, 3, 2, 3, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 5, 3), 0, 0);
    issue(mk(3, 1, 4, 99, 1, 0, 0, 3'b001, 1, 0, 0, 2'b01, 2'b00, 0, 4, 1), 0, 0);
    issue(mk(5, 6, 12, 32'hDDAD, 0, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b10, 32'h100, 32'hDEAD, 32'h100), 0, 0);
    issue(mk(0, 7, 13, 32'h55, 32'h20, 0, 0, 3'b000, 1, 0, 0, 2'b01, 2'b00, 0, 32'h20, 32'h20), 0, 0);
    issue(mk(8, 0, 14, 3, 32'h99, 0, 0, 3'b011, 1, 0, 0, 2'b00, 2'b01, 0, 3, 0), 0, 0);
    issue(mk(9, 10, 15, 32'hFF, 4, 32'h0F, 1, 3'b010, 1, 0, 0, 2'b11, 2'b11, 0, 32'h0F, 4), 0, 0);
    // Load-use on r2, then a load whose rt match is masked by the immediate
    issue(mk(11, 12, 2, 32'h1000, 7, 4, 1, 3'b000, 1, 1, 0, 2'b00, 2'b00, 0, 32'h1004, 7), 0, 0);
    issue(mk(2, 2, 5, 32'h30, 32'h30, 0, 0, 3'b000, 1, 0, 0, 2'b10, 2'b10, 32'h50, 32'hA0, 32'h50), 1, 0);
    issue(mk(13, 14, 6, 32'h2000, 9, 8, 1, 3'b000, 1, 1, 0, 2'b00, 2'b00, 0, 32'h2008, 9), 0, 1);
    issue(mk(20, 6, 7, 1, 32'h11, 2, 1, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 3, 32'h11), 0, 0);
    // Flush coinciding with an interlock
    issue(mk(15, 16, 8, 32'h10, 0, 0, 1, 3'b000, 1, 1, 0, 2'b00, 2'b00, 0, 32'h10, 0), 0, 0);
    t = mk(8, 17, 9, 32'h10, 1, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    t.fl = 1'b1;
    issue(t, 1, 0);
    issue(mk(8, 17, 9, 32'h10, 1, 0, 0, 3'b000, 1, 0, 0, 2'b10, 2'b00, 32'h77, 32'h78, 1), 0, 0);
    issue(mk(18, 19, 10, 32'hFFFFFFFF, 1, 0, 0, 3'b100, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1), 0, 1);
    issue(mk(18, 19, 22, 1, 32'hFFFFFFFF, 0, 0, 3'b100, 0, 0, 1, 2'b00, 2'b00, 0, 0, 32'hFFFFFFFF), 0, 0);
    issue(mk(21, 23, 11, 0, 1, 0, 0, 3'b001, 1, 0, 0, 2'b00, 2'b00, 0, 32'hFFFFFFFF, 1), 0, 0);
    idle();
    idle();
    idle();

    // Reset mid-stream discards in-flight work
    t = mk(24, 25, 16, 1, 2, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 3, 2);
    t.nopush = 1'b1;
    issue(t, 0, 0);
    t = mk(26, 27, 17, 4, 4, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 8, 4);
    t.nopush = 1'b1;
    issue(t, 0, 0);
    @(posedge clk);
    #1;
    chk("inflight_valid", {31'b0, exmem_valid}, 32'd1);
    chk("inflight_idex_rs", {27'b0, idex_rs}, 32'd26);
    rst_n = 0;
    #1;
    chk("midrst_exmem_valid", {31'b0, exmem_valid}, 32'd0);
    chk("midrst_alu_result", exmem_alu_result, 32'd0);
    chk("midrst_idex_rs", {27'b0, idex_rs}, 32'd0);
    chk("midrst_idex_rt", {27'b0, idex_rt}, 32'd0);
    chk("midrst_ctl", {29'b0, exmem_regwrite, exmem_memread, exmem_memwrite}, 32'd0);
    @(negedge clk);
    zero_inputs();
    pfa = 2'b00; pfb = 2'b00; pmwb = 32'h0;
    rst_n = 1;
    issue(mk(1, 2, 3, 5, 7, 0, 0, 3'b000, 1, 0, 0, 2'b00, 2'b00, 0, 12, 7), 0, 0);
    idle();
    idle();
    idle();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Execute-stage datapath of the 5-stage pipeline: owns the ID/EX and EX/MEM pipeline registers, the operand muxes driven by the forwarding unit's ForwardA/ForwardB codes, a small ALU, and load-use hazard detection.
- It presents the ID/EX source register numbers and the EX/MEM / MEM/WB destinations to the forwarding unit, and consumes the returned select codes in the same cycle.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-number width

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_W  source register A number
id_rt  input  REG_W  source register B number
id_dest  input  REG_W  destination register, already rd/rt selected upstream
id_rs_data  input  DATA_W  register-file read data A
id_rt_data  input  DATA_W  register-file read data B
id_imm  input  DATA_W  sign-extended immediate
id_alusrc  input  1  1 = operand B is the immediate
id_aluop  input  3  000 add, 001 sub, 010 and, 011 or, 100 slt, others add
id_regwrite / id_memread / id_memwrite  input  1 each  control bits
flush  input  1  squash the instruction entering ID/EX
forward_a, forward_b  input  2 each  00 register file, 01 EX/MEM, 10 MEM/WB, 11 treated as 00
memwb_dest  input  REG_W  MEM/WB destination, passed through for the forwarding unit
memwb_result  input  DATA_W  MEM/WB writeback value
idex_rs, idex_rt  output  REG_W  to forwarding unit Rs/Rt
exmem_dest_fwd  output  REG_W  to forwarding unit ExMemReg: exmem_dest when exmem_valid && exmem_regwrite, else 0
memwb_dest_fwd  output  REG_W  to forwarding unit MemWBReg: memwb_dest passed through
stall  output  1  load-use interlock; upstream holds PC and IF/ID
exmem_valid  output  1  EX/MEM holds a real instruction
exmem_alu_result  output  DATA_W  registered ALU result
exmem_store_data  output  DATA_W  registered forwarded operand B, taken before the immediate mux
exmem_dest  output  REG_W  registered destination
exmem_regwrite / exmem_memread / exmem_memwrite  output  1 each  registered control bits

Behaviour:
- Reset (rst_n low, asynchronous) clears every ID/EX and EX/MEM register to 0, including all valid and control bits. Consequently stall = 0, idex_rs/idex_rt = 0, and every exmem_* output = 0. Release is synchronous to the next clk edge.
- Operand A = 0 if idex_rs == 0. Otherwise it is selected by forward_a: 00 gives idex_rs_data, 01 gives exmem_alu_result, 10 gives memwb_result, 11 gives idex_rs_data.
- Operand B (fwdB) follows the same rule using idex_rt / forward_b. The $0 check is made here and takes priority over any forward code received.
- ALU operand 2 = idex_imm if idex_alusrc, else fwdB.
- ALU arithmetic is modulo 2^DATA_W. slt is a signed compare that produces 1 or 0.
- Load-use stall (combinational):
  - stall = idex_valid && idex_memread && idex_dest != 0 && id_valid && (idex_dest == id_rs || (idex_dest == id_rt && !id_alusrc)).
- ID/EX update on each clk edge:
  - flush = 1: load a bubble (valid and all controls 0, register numbers 0). Flush has priority over stall.
  - else stall = 1: load a bubble; the upstream instruction is held by the upstream stages and re-presented next cycle.
  - else: load all id_* fields. valid = id_valid, and controls are ANDed with id_valid.
- EX/MEM update: loads every edge, never stalls. exmem_valid = idex_valid, controls are copied, exmem_alu_result = ALU output, exmem_store_data = fwdB.
- Latency: one instruction enters ID/EX on edge N and its result appears on exmem_* after edge N+1. A stall adds exactly one bubble cycle.
- A flush and a stall in the same cycle produce one bubble; the stall deasserts next cycle because the load is not in EX/MEM's hazard window.
- Reset asserted mid-stream discards all in-flight instructions immediately; no partial state is retained.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> all exmem_* = 0 and stall = 0. After release, a first add with rs_data=5, rt_data=7 gives exmem_alu_result = 12 two edges later.
2. EX/MEM forward: add r3 = 2+3, then sub r4 = r3 - r1 with r1=1 and forward_a=01 -> second exmem_alu_result = 4, not the stale register-file value.
3. MEM/WB forward: forward_b=10, memwb_result=0x100, alusrc=0, rt_data=0 -> exmem_store_data = 0x100.
4. $0 guard: idex_rs=0, forward_a=01, exmem_alu_result=0xDEAD -> operand A = 0.
5. Load-use: lw r2 followed by add r5 = r2 + r2 -> stall=1 for exactly one cycle, a bubble appears in EX/MEM (exmem_valid=0), then the add proceeds. With alusrc=1 and only rt matching -> no stall.
6. Flush and stall in the same cycle -> one bubble; in a separate run, slt of -1 vs 1 -> exmem_alu_result = 1.
